spi_reg_sequencer: RTL and testbench

- Sequences the motor controller's single-port control register file on behalf of the SPI slave.
- Decodes the command byte: bit 7 = R/nW, bits 6:3 = address, bits 2:0 ignored.
- Issues register read/write strobes and returns read data to the SPI shifter.
- Arbitrates register-file access between the SPI host and one internal requester (tach/status capture).
- Sits between the clk-domain SPI byte deserializer and the register bank; drives the watchdog kick.

---
 rtl/spi_reg_sequencer.sv | 164 ++++++++++++++++
 tb/tb_spi_reg_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_sequencer.sv
// SPI command sequencer for the motor controller register file.
// Optional burst auto-increment: define SPI_REG_SEQ_AUTO_INC_EN.
module spi_reg_sequencer #(
    parameter int          NUM_REGS = 16,
    parameter logic [15:0] RO_MASK  = 16'h0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    input  logic       int_req,
    input  logic [3:0] int_addr,
    input  logic [7:0] int_wdata,
    output logic       int_gnt,
    output logic       wdog_kick,
    output logic       err_abort
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_RDWAIT = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0] r_state;
    logic       r_rw;
    logic [3:0] r_ptr;
    logic       r_done_one;
    logic       r_spi_we;
    logic       r_spi_re;
    logic [3:0] r_saddr;
    logic [7:0] r_wdata;
    logic       r_rd_oor;
    logic       r_tx_load;
    logic       r_kick;
    logic       r_abort;
    logic       r_alive;

    logic       w_int_gnt;
    logic       w_unused;

    // Command bits 2:0 carry no meaning.
    assign w_unused = &{1'b0, rx_byte[2:0]};

`ifdef SPI_REG_SEQ_AUTO_INC_EN
    logic [3:0] w_ptr_nxt;
    assign w_ptr_nxt = r_ptr + 4'd1;
`endif

    function automatic logic f_oor(input logic [3:0] a);
        return (int'(a) >= NUM_REGS);
    endfunction

    function automatic logic f_wsup(input logic [3:0] a);
        return f_oor(a) || RO_MASK[a];
    endfunction

    // Transaction FSM; every strobe is a registered one-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rw       <= 1'b0;
            r_ptr      <= 4'd0;
            r_done_one <= 1'b0;
            r_spi_we   <= 1'b0;
            r_spi_re   <= 1'b0;
            r_saddr    <= 4'd0;
            r_wdata    <= 8'h00;
            r_rd_oor   <= 1'b0;
            r_tx_load  <= 1'b0;
            r_kick     <= 1'b0;
            r_abort    <= 1'b0;
            r_alive    <= 1'b0;
        end else begin
            r_alive   <= 1'b1;
            r_spi_we  <= 1'b0;
            r_spi_re  <= 1'b0;
            r_tx_load <= 1'b0;
            r_kick    <= 1'b0;
            r_abort   <= 1'b0;
            if (!ss) begin
                // Deselect wins over any byte arriving in the same cycle.
                if ((r_state == S_RDWAIT || r_state == S_DATA) && !r_done_one)
                    r_abort <= 1'b1;
                r_state    <= S_IDLE;
                r_done_one <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_CMD;
                    S_CMD: begin
                        if (rx_valid) begin
                            r_rw  <= rx_byte[7];
                            r_ptr <= rx_byte[6:3];
                            if (rx_byte[7]) begin
                                r_spi_re <= 1'b1;
                                r_saddr  <= rx_byte[6:3];
                                r_rd_oor <= f_oor(rx_byte[6:3]);
                                r_state  <= S_RDWAIT;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_RDWAIT: begin
                        r_tx_load <= 1'b1;
                        r_state   <= S_DATA;
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            r_done_one <= 1'b1;
                            if (!r_rw) begin
                                if (!f_wsup(r_ptr)) begin
                                    r_spi_we <= 1'b1;
                                    r_kick   <= 1'b1;
                                end
                                r_saddr <= r_ptr;
                                r_wdata <= rx_byte;
`ifdef SPI_REG_SEQ_AUTO_INC_EN
                                r_ptr <= w_ptr_nxt;
`else
                                r_state <= S_DONE;
`endif
                            end else begin
`ifdef SPI_REG_SEQ_AUTO_INC_EN
                                r_ptr    <= w_ptr_nxt;
                                r_spi_re <= 1'b1;
                                r_saddr  <= w_ptr_nxt;
                                r_rd_oor <= f_oor(w_ptr_nxt);
                                r_state  <= S_RDWAIT;
`else
                                r_state <= S_DONE;
`endif
                            end
                        end
                    end
                    S_DONE: r_state <= S_DONE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Internal writer takes any cycle the SPI path leaves the bank free.
    assign w_int_gnt = r_alive & int_req & ~r_spi_we & ~r_spi_re;

    assign int_gnt   = w_int_gnt;
    assign reg_we    = r_spi_we | w_int_gnt;
    assign reg_re    = r_spi_re;
    assign reg_addr  = w_int_gnt ? int_addr  : r_saddr;
    assign reg_wdata = w_int_gnt ? int_wdata : r_wdata;
    assign tx_load   = r_tx_load;
    assign tx_byte   = (r_tx_load && !r_rd_oor) ? reg_rdata : 8'h00;
    assign wdog_kick = r_kick;
    assign err_abort = r_abort;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Scoreboard bench for spi_reg_sequencer.
// Reference model tracks register contents and expected bus events.
module tb_spi_reg_sequencer;

    localparam int          NREG = 12;
    localparam logic [15:0] ROM  = 16'h0082;
`ifdef SPI_REG_SEQ_AUTO_INC_EN
    localparam int MAXN = 4;
`else
    localparam int MAXN = 2;
`endif

    logic       clk = 1'b0;
    logic       reset, ss, rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte, reg_wdata, reg_rdata, int_wdata;
    logic       tx_load, reg_we, reg_re, int_req, int_gnt;
    logic       wdog_kick, err_abort;
    logic [3:0] reg_addr, int_addr;

    always #5 clk = ~clk;

    spi_reg_sequencer #(.NUM_REGS(NREG), .RO_MASK(ROM)) dut (
        .clk(clk), .reset(reset), .ss(ss),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_load(tx_load),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .int_req(int_req), .int_addr(int_addr), .int_wdata(int_wdata),
        .int_gnt(int_gnt), .wdog_kick(wdog_kick), .err_abort(err_abort)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_rx = 0;
    int n_abort_exp = 0;
    int n_abort_seen = 0;

    logic [7:0]  init_val[16];
    logic [7:0]  exp_mem[16];
    logic [7:0]  bank[16];
    bit          load_bank;
    logic [11:0] sq[$];
    logic [11:0] iq[$];
    logic [3:0]  rq[$];
    logic [7:0]  tq[$];

    bit         int_en = 0;
    bit         drv_req = 0, dir_req = 0;
    logic [3:0] drv_addr = 4'd0, dir_addr = 4'd0;
    logic [7:0] drv_wd = 8'h00, dir_wd = 8'h00;

    assign int_req   = drv_req | dir_req;
    assign int_addr  = dir_req ? dir_addr : drv_addr;
    assign int_wdata = dir_req ? dir_wd : drv_wd;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank environment: read data one cycle after reg_re.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_rdata <= 8'h00;
            if (load_bank)
                for (int i = 0; i < 16; i++) bank[i] <= init_val[i];
        end else begin
            if (reg_re) reg_rdata <= bank[reg_addr];
            if (reg_we) bank[reg_addr] <= reg_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit writable(input logic [3:0] a);
        return (int'(a) < NREG) && !ROM[a];
    endfunction

    function automatic logic [7:0] rd(input logic [3:0] a);
        return (int'(a) < NREG) ? exp_mem[a] : 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b; rx_valid = 1'b1; t_rx = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (7 + $urandom_range(0, 4)) @(posedge clk);
    endtask

    task automatic txn(input bit has_cmd, input logic [7:0] cmd, input int n,
                       input bit collide, input logic [31:0] dw);
        logic [3:0] a, wa;
        logic [7:0] b;
        bit rw;
        @(posedge clk); #1 ss = 1'b1;
        repeat (2) @(posedge clk);
        if (has_cmd) begin
            rw = cmd[7];
            a  = cmd[6:3];
            if (rw) begin rq.push_back(a); tq.push_back(rd(a)); end
            send_byte(cmd);
            for (int i = 0; i < n; i++) begin
                b = dw[8*i +: 8];
`ifdef SPI_REG_SEQ_AUTO_INC_EN
                if (!rw) begin
                    wa = a + i[3:0];
                    if (writable(wa)) begin
                        sq.push_back({wa, b}); exp_mem[wa] = b;
                    end
                end else begin
                    wa = a + i[3:0] + 4'd1;
                    rq.push_back(wa); tq.push_back(rd(wa));
                end
`else
                if (i == 0 && !rw && writable(a)) begin
                    sq.push_back({a, b}); exp_mem[a] = b;
                end
`endif
                send_byte(b);
            end
            if (n == 0) n_abort_exp++;
        end
        @(posedge clk); #1 ss = 1'b0;
        if (collide) begin
            rx_byte = 8'($urandom); rx_valid = 1'b1; t_rx = cyc;
            @(posedge clk); #1 rx_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_drv_idle();
        int_en = 0;
        for (int i = 0; i < 20 && drv_req; i++) @(posedge clk);
        chk("int_drv_idle", {31'd0, drv_req}, 0);
    endtask

    // Monitor: pop and compare every bus event the DUT presents.
    always @(negedge clk) begin : mon
        logic [11:0] e;
        logic [3:0]  a;
        logic [7:0]  b;
        if (!reset) begin
            if (reg_we || reg_re) chk("strobe_excl", {31'd0, reg_we & reg_re}, 0);
            if (int_gnt) begin
                if (iq.size() == 0) chk("unexpected_int_gnt", {31'd0, int_gnt}, 0);
                else begin
                    e = iq.pop_front();
                    chk("int_write", {reg_we, reg_addr, reg_wdata}, {1'b1, e});
                end
            end else if (reg_we) begin
                if (sq.size() == 0) chk("unexpected_spi_we", {31'd0, reg_we}, 0);
                else begin
                    e = sq.pop_front();
                    chk("spi_write", {reg_addr, reg_wdata}, e);
                    chk("wdog_kick_on_write", {31'd0, wdog_kick}, 1);
                end
            end
            if (wdog_kick && !(reg_we && !int_gnt))
                chk("wdog_kick_spurious", {31'd0, wdog_kick}, 0);
            if (reg_re) begin
                if (rq.size() == 0) chk("unexpected_reg_re", {31'd0, reg_re}, 0);
                else begin
                    a = rq.pop_front();
                    chk("reg_re_addr", reg_addr, a);
                    chk("reg_re_latency", cyc - t_rx, 1);
                end
            end
            if (tx_load) begin
                if (tq.size() == 0) chk("unexpected_tx_load", {31'd0, tx_load}, 0);
                else begin
                    b = tq.pop_front();
                    chk("tx_byte", tx_byte, b);
                    chk("tx_latency", cyc - t_rx, 2);
                end
            end
            if (err_abort) begin
                n_abort_seen++;
                chk("err_abort_expected", {31'd0, n_abort_seen <= n_abort_exp}, 1);
            end
        end
    end

    // Random internal requester on addresses SPI can never read back.
    initial begin : int_drv
        int w;
        bit got;
        forever begin
            @(posedge clk); #1;
            if (int_en && !reset && $urandom_range(0, 3) == 0) begin
                drv_addr = 4'(12 + $urandom_range(0, 3));
                drv_wd   = 8'($urandom);
                drv_req  = 1'b1;
                iq.push_back({drv_addr, drv_wd});
                w = 0; got = 0;
                while (!got && w < 4) begin
                    @(negedge clk); w++; got = int_gnt;
                end
                chk("int_grant_wait", {31'd0, got && w <= 2}, 1);
                @(posedge clk); #1 drv_req = 1'b0;
            end
        end
    end

    initial begin : main
        bit hc, col;
        int n;
        logic [7:0] cmd;
        reset = 1'b1; ss = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        load_bank = 1'b1;
        dir_req = 1'b1; dir_addr = 4'd5; dir_wd = 8'h55;
        for (int i = 0; i < 16; i++) begin
            init_val[i] = 8'($urandom);
            exp_mem[i]  = init_val[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_tx_load", {31'd0, tx_load}, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_reg_we", {31'd0, reg_we}, 0);
        chk("rst_reg_re", {31'd0, reg_re}, 0);
        chk("rst_int_gnt", {31'd0, int_gnt}, 0);
        chk("rst_wdog_kick", {31'd0, wdog_kick}, 0);
        chk("rst_err_abort", {31'd0, err_abort}, 0);
        dir_req = 1'b0;
        @(posedge clk); #1 reset = 1'b0; load_bank = 1'b0;
        repeat (3) @(posedge clk);

        txn(1, 8'h10, 1, 0, 32'h80);
        txn(1, 8'h00, 1, 0, 32'h5A);
        txn(1, 8'h80, 1, 0, 32'h00);
        txn(1, 8'h10, 0, 0, 32'h0);
        txn(1, 8'h10, 1, 0, 32'h3C);
        txn(1, 8'h90, 1, 0, 32'h0);

        // SPI write and a held internal request in the same cycle.
        @(posedge clk); #1 ss = 1'b1;
        repeat (2) @(posedge clk);
        send_byte(8'h10);
        sq.push_back({4'd2, 8'h44}); exp_mem[2] = 8'h44;
        @(posedge clk); #1;
        rx_byte = 8'h44; rx_valid = 1'b1; t_rx = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        dir_req = 1'b1; dir_addr = 4'd3; dir_wd = 8'h33;
        iq.push_back({4'd3, 8'h33});
        @(negedge clk);
        chk("cont_spi_first", {reg_we, int_gnt, reg_addr}, {1'b1, 1'b0, 4'd2});
        @(negedge clk);
        chk("cont_int_next", {int_gnt, reg_we, reg_addr, reg_wdata},
            {1'b1, 1'b1, 4'd3, 8'h33});
        @(posedge clk); #1 dir_req = 1'b0;
        exp_mem[3] = 8'h33;
        repeat (8) @(posedge clk);
        #1 ss = 1'b0;
        repeat (3) @(posedge clk);
        txn(1, 8'h98, 1, 0, 32'h0);

        txn(1, 8'h08, 1, 0, 32'hEE);
        txn(1, 8'h68, 1, 0, 32'hEE);
        txn(1, 8'hE8, 1, 0, 32'h0);
        txn(1, 8'h88, 1, 0, 32'h0);
        txn(0, 8'h00, 0, 1, 32'h0);
        txn(1, 8'h20, 0, 1, 32'h0);
        txn(1, 8'hA0, 0, 0, 32'h0);
`ifdef SPI_REG_SEQ_AUTO_INC_EN
        txn(1, 8'h78, 2, 0, 32'h0000A2A1);
        txn(1, 8'h58, 4, 0, 32'h04030201);
        txn(1, 8'hD8, 3, 0, 32'h0);
        txn(1, 8'h80, 4, 1, 32'h0);
`endif

        // Reset in the middle of a write transaction.
        @(posedge clk); #1 ss = 1'b1;
        repeat (2) @(posedge clk);
        send_byte(8'h18);
        #1 reset = 1'b1; ss = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        txn(1, 8'h98, 1, 0, 32'h0);
        txn(1, 8'h18, 1, 0, 32'h77);
        txn(1, 8'h98, 1, 0, 32'h0);

        int_en = 1;
        for (int k = 0; k < 60; k++) begin
            hc  = ($urandom_range(0, 9) != 0);
            cmd = 8'($urandom);
            n   = $urandom_range(0, MAXN);
            col = ($urandom_range(0, 3) == 0);
            txn(hc, cmd, n, col, $urandom);
        end
        wait_drv_idle();
        repeat (20) @(posedge clk);
        chk("left_spi_writes", sq.size(), 0);
        chk("left_int_writes", iq.size(), 0);
        chk("left_reads", rq.size(), 0);
        chk("left_tx", tq.size(), 0);
        chk("abort_count", n_abort_seen, n_abort_exp);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
